// File: rtl/npn_lut_eval.sv
// rtl/npn_lut_eval.sv - pipelined NPN-transformed truth-table evaluator with streamed, drain-then-commit reconfiguration.
// Optional macro NPN_PERM_EN builds the input permutation stage; without it the transform is negation only.
module npn_lut_eval #(
  parameter int N  = 4,
  parameter int CW = 8,
  parameter int PW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CW-1:0]   cfg_data,
  input  logic            cfg_last,
  input  logic [N*PW-1:0] cfg_perm,
  input  logic [N-1:0]    cfg_neg,
  input  logic            cfg_oneg,
  output logic            cfg_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_y
);

  localparam int TBL   = 1 << N;
  localparam int BEATS = TBL / CW;
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [TBL-1:0]    sh_tbl_q, sh_tbl_d;
  logic [N-1:0]      sh_neg_q, sh_neg_d;
  logic              sh_oneg_q, sh_oneg_d;
  logic [TBL-1:0]    tbl_q;
  logic [N-1:0]      neg_q;
  logic              oneg_q;

  logic              s1_valid_q, s2_valid_q;
  logic [N-1:0]      s1_x_q;
  logic              s2_y_q;
  logic [N-1:0]      x_tr;

  logic              beat_acc, at_end, pipe_empty, commit;
  logic              s1_can_take, s2_can_take;

`ifdef NPN_PERM_EN
  function automatic logic [N*PW-1:0] ident_perm();
    logic [N*PW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*PW +: PW] = PW'(i);
    return p;
  endfunction

  localparam logic [N*PW-1:0] PERM_ID = ident_perm();

  logic [N*PW-1:0]   sh_perm_q, sh_perm_d;
  logic [N*PW-1:0]   perm_q;
  logic [PW-1:0]     sel;
`else
  logic              unused_perm;
  assign unused_perm = ^cfg_perm;
`endif

  assign pipe_empty  = !s1_valid_q && !s2_valid_q;
  assign s2_can_take = !s2_valid_q || out_ready;
  assign s1_can_take = !s1_valid_q || s2_can_take;
  assign beat_acc    = cfg_valid && cfg_ready;
  assign at_end      = (cnt_q == CNTW'(BEATS - 1));

  // Config FSM: state register plus shadow/active configuration storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      sh_tbl_q  <= '0;
      sh_neg_q  <= '0;
      sh_oneg_q <= 1'b0;
      tbl_q     <= '0;
      neg_q     <= '0;
      oneg_q    <= 1'b0;
`ifdef NPN_PERM_EN
      sh_perm_q <= PERM_ID;
      perm_q    <= PERM_ID;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      sh_tbl_q  <= sh_tbl_d;
      sh_neg_q  <= sh_neg_d;
      sh_oneg_q <= sh_oneg_d;
`ifdef NPN_PERM_EN
      sh_perm_q <= sh_perm_d;
`endif
      if (commit) begin
        tbl_q  <= sh_tbl_q;
        neg_q  <= sh_neg_q;
        oneg_q <= sh_oneg_q;
`ifdef NPN_PERM_EN
        perm_q <= sh_perm_q;
`endif
      end
    end
  end

  // Next state: a last flag that disagrees with the beat position is a framing error
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    sh_tbl_d  = sh_tbl_q;
    sh_neg_d  = sh_neg_q;
    sh_oneg_d = sh_oneg_q;
`ifdef NPN_PERM_EN
    sh_perm_d = sh_perm_q;
`endif
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (beat_acc) begin
          sh_tbl_d[int'(cnt_q)*CW +: CW] = cfg_data;
          if (cfg_last != at_end) begin
            err_d    = 1'b1;
            state_d  = S_IDLE;
            cnt_d    = '0;
            sh_tbl_d = '0;
          end else if (cfg_last) begin
            state_d   = S_DRAIN;
            cnt_d     = '0;
            sh_neg_d  = cfg_neg;
            sh_oneg_d = cfg_oneg;
`ifdef NPN_PERM_EN
            sh_perm_d = cfg_perm;
`endif
          end else begin
            state_d = S_LOAD;
            cnt_d   = cnt_q + CNTW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (pipe_empty) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cfg_ready = (state_q != S_DRAIN);
    in_ready  = (state_q != S_DRAIN) && s1_can_take;
    commit    = (state_q == S_DRAIN) && pipe_empty;
    cfg_err   = err_q;
  end

  always_comb begin
    x_tr = '0;
`ifdef NPN_PERM_EN
    sel = '0;
`endif
    for (int i = 0; i < N; i++) begin
`ifdef NPN_PERM_EN
      sel = perm_q[i*PW +: PW];
      if (int'(sel) < N) x_tr[i] = in_x[sel] ^ neg_q[i];
      else               x_tr[i] = in_x[i] ^ neg_q[i];
`else
      x_tr[i] = in_x[i] ^ neg_q[i];
`endif
    end
  end

  // Two-stage pipeline: stage 1 holds the transformed vector, stage 2 the looked-up result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= 1'b0;
    end else begin
      if (s1_can_take) begin
        s1_valid_q <= in_valid && in_ready;
        if (in_valid && in_ready) s1_x_q <= x_tr;
      end
      if (s2_can_take) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_y_q <= tbl_q[s1_x_q] ^ oneg_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;

endmodule

// File: tb/tb_npn_lut_eval.sv
// tb/tb_npn_lut_eval.sv - directed self-checking bench for npn_lut_eval (N=4, CW=8).
module tb_npn_lut_eval;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_ready, cfg_last, cfg_oneg, cfg_err;
  logic [7:0] cfg_data;
  logic [7:0] cfg_perm;
  logic [3:0] cfg_neg;
  logic       in_valid, in_ready, out_valid, out_ready, out_y;
  logic [3:0] in_x;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] PERM_IDENT = {2'd3, 2'd2, 2'd1, 2'd0};

  always #5 clk = ~clk;

  npn_lut_eval #(.N(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cfg_perm(cfg_perm), .cfg_neg(cfg_neg), .cfg_oneg(cfg_oneg), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  task automatic send_beat(input logic [7:0] d, input logic last);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] t, input logic [3:0] neg, input logic oneg,
                          input logic [7:0] perm);
    cfg_neg  = neg;
    cfg_oneg = oneg;
    cfg_perm = perm;
    send_beat(t[7:0], 1'b0);
    send_beat(t[15:8], 1'b1);
    repeat (3) @(posedge clk);
  endtask

  task automatic eval(input logic [3:0] x, output logic y);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_x      = x;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk); n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL eval_timeout x=%h out_valid=%b required 1", x, out_valid);
    end
    y = out_y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_y !== 1'b0) begin errors++; $display("FAIL rst_out_y got %b want 0", out_y); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready got %b want 1", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got %b want 0", cfg_err); end
    in_valid = 1'b1;
    in_x     = 4'hF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b want 1", out_valid); end
    checks++; if (out_y !== 1'b0) begin errors++; $display("FAIL rst_eval_xF got %b want 0", out_y); end
    @(posedge clk);
  endtask

  task automatic test_parity();
    logic       y;
    logic [3:0] xe;
    load_cfg(16'h6996, 4'b0000, 1'b0, PERM_IDENT);
    eval(4'b0001, y);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL parity_x1 got %b want 1", y); end
    eval(4'b0011, y);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL parity_x3 got %b want 0", y); end
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        xe = 4'(j - 2);
        checks++;
        if (out_valid !== 1'b1 || out_y !== ^xe) begin
          errors++;
          $display("FAIL b2b_x%0d got valid=%b y=%b want valid=1 y=%b", j - 2, out_valid, out_y, ^xe);
        end
      end
      if (j < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
      end
      in_valid = (j < 8);
      in_x     = 4'(j);
    end
    in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_neg();
    logic y;
    load_cfg(16'h8000, 4'b1111, 1'b0, PERM_IDENT);
    eval(4'b0000, y);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL neg_x0 got %b want 1", y); end
    eval(4'b1111, y);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL neg_xF got %b want 0", y); end
    load_cfg(16'h8000, 4'b1111, 1'b1, PERM_IDENT);
    eval(4'b0000, y);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL oneg_x0 got %b want 0", y); end
  endtask

  task automatic test_perm();
    logic y;
    logic e8, e1;
`ifdef NPN_PERM_EN
    e8 = 1'b1; e1 = 1'b0;
`else
    e8 = 1'b0; e1 = 1'b1;
`endif
    load_cfg(16'hAAAA, 4'b0000, 1'b0, {2'd3, 2'd2, 2'd1, 2'd3});
    eval(4'b1000, y);
    checks++; if (y !== e8) begin errors++; $display("FAIL perm_x8 got %b want %b", y, e8); end
    eval(4'b0001, y);
    checks++; if (y !== e1) begin errors++; $display("FAIL perm_x1 got %b want %b", y, e1); end
  endtask

  task automatic test_drain();
    logic y;
    logic got[$];
    int   n;
    load_cfg(16'h00FF, 4'b0000, 1'b0, PERM_IDENT);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 4'd0;
    @(posedge clk); #1;
    in_x = 4'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_beat(8'h00, 1'b0);
    send_beat(8'hFF, 1'b1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || cfg_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 1'b1) begin
        errors++;
        $display("FAIL drain_hold got in_rdy=%b cfg_rdy=%b ov=%b y=%b want 0 0 1 1",
                 in_ready, cfg_ready, out_valid, out_y);
      end
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      if (out_valid) got.push_back(out_y);
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL drain_cfg_ready got %b want 0", cfg_ready); end
      @(negedge clk);
      n++;
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_commit_timeout in_ready %b want 1", in_ready); end
    checks++;
    if (got.size() != 2 || got[0] !== 1'b1 || got[1] !== 1'b1) begin
      errors++;
      $display("FAIL drain_old_results got count=%0d want 2 results of 1", got.size());
    end
    eval(4'd0, y);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL drain_new_x0 got %b want 0", y); end
    eval(4'd8, y);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL drain_new_x8 got %b want 1", y); end
  endtask

  task automatic test_framing();
    logic y;
    send_beat(8'hAA, 1'b1);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_early_last got %b want 1", cfg_err); end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b want 0", cfg_err); end
    eval(4'd0, y);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL err_keep_x0 got %b want 0", y); end
    eval(4'd8, y);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL err_keep_x8 got %b want 1", y); end
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_missing_last got %b want 1", cfg_err); end
    eval(4'd8, y);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL err2_keep_x8 got %b want 1", y); end
    send_beat(8'h55, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    eval(4'd8, y);
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL rst_mid_load_x8 got %b want 0", y); end
    cfg_neg = 4'b0000; cfg_oneg = 1'b0; cfg_perm = PERM_IDENT;
    send_beat(8'h96, 1'b0);
    send_beat(8'h69, 1'b1);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reload_err got %b want 0", cfg_err); end
    repeat (2) @(posedge clk);
    eval(4'b0001, y);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL reload_x1 got %b want 1", y); end
    eval(4'b0111, y);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL reload_x7 got %b want 1", y); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    cfg_perm = PERM_IDENT; cfg_neg = '0; cfg_oneg = 1'b0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    test_reset();
    test_parity();
    test_neg();
    test_perm();
    test_drain();
    test_framing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
